// File: rtl/img_sobel_dp.sv
// Image controller datapath: bus address generation, three-row source capture and a
// one-pixel-per-cycle 3x3 Sobel window packing four saturated magnitudes per word.
module img_sobel_dp #(
  parameter int unsigned COL_MAX = 600,
  parameter int unsigned ROW_MAX = 400,
  parameter int unsigned AW      = 20,
  parameter logic [AW-1:0] SRC_BASE = AW'(20'h00000),
  parameter logic [AW-1:0] DST_BASE = AW'(20'h40000)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load0,
  input  logic          load1,
  input  logic          load2,
  input  logic          en_pipe,
  input  logic          inc_src,
  input  logic          inc_dec,
  input  logic          rst_a,
  input  logic          bus_we_i,
  input  logic          bus_ack_i,
  input  logic [31:0]   bus_dat_i,
  output logic [AW-1:0] bus_adr_o,
  output logic [31:0]   bus_dat_o,
  output logic          res_vld
);

  localparam int unsigned WPR     = COL_MAX / 4;
  localparam int unsigned OFF_MAX = ROW_MAX * WPR - 1;
  localparam int unsigned PW      = 8;
  localparam int unsigned SW      = 10;
  localparam int unsigned MW      = 12;

  logic [AW-1:0] src_off_q, src_off_d;
  logic [AW-1:0] dst_off_q, dst_off_d;
  logic [31:0]   row_q [3];
  logic [31:0]   row_d [3];
  logic [PW-1:0] p_q [3][3];
  logic [PW-1:0] p_d [3][3];
  logic [1:0]    pix_cnt_q, pix_cnt_d;
  logic          s2_vld_q, s2_vld_d;
  logic [1:0]    s2_tag_q, s2_tag_d;
  logic [31:0]   dat_q, dat_d;
  logic          vld_q, vld_d;

  logic [AW-1:0] row_off;
  logic [SW-1:0] gx_pos, gx_neg, gy_pos, gy_neg, gx_abs, gy_abs;
  logic [MW-1:0] mag;
  logic [PW-1:0] mag_sat;

  // Bus address: destination on writes, otherwise the source row selected by the active load
  always_comb begin
    row_off = '0;
    if (load2)      row_off = AW'(2 * WPR);
    else if (load1) row_off = AW'(WPR);
    if (bus_we_i) bus_adr_o = DST_BASE + dst_off_q;
    else          bus_adr_o = SRC_BASE + src_off_q + row_off;
  end

  // Sobel magnitude over the current (already shifted) window
  always_comb begin
    gx_pos = SW'(p_q[0][2]) + (SW'(p_q[1][2]) << 1) + SW'(p_q[2][2]);
    gx_neg = SW'(p_q[0][0]) + (SW'(p_q[1][0]) << 1) + SW'(p_q[2][0]);
    gy_pos = SW'(p_q[2][0]) + (SW'(p_q[2][1]) << 1) + SW'(p_q[2][2]);
    gy_neg = SW'(p_q[0][0]) + (SW'(p_q[0][1]) << 1) + SW'(p_q[0][2]);
    gx_abs = (gx_pos >= gx_neg) ? (gx_pos - gx_neg) : (gx_neg - gx_pos);
    gy_abs = (gy_pos >= gy_neg) ? (gy_pos - gy_neg) : (gy_neg - gy_pos);
    mag    = MW'(gx_abs) + MW'(gy_abs);
    mag_sat = (mag > MW'(255)) ? 8'hFF : mag[PW-1:0];
  end

  always_comb begin
    src_off_d = src_off_q;
    dst_off_d = dst_off_q;
    row_d     = row_q;
    p_d       = p_q;
    pix_cnt_d = pix_cnt_q;
    s2_vld_d  = en_pipe;
    s2_tag_d  = pix_cnt_q;
    dat_d     = dat_q;
    vld_d     = vld_q;

    if (rst_a) begin
      src_off_d = '0;
      dst_off_d = '0;
    end else begin
      if (inc_src) src_off_d = (src_off_q == AW'(OFF_MAX)) ? '0 : src_off_q + AW'(1);
      if (inc_dec) dst_off_d = (dst_off_q == AW'(OFF_MAX)) ? '0 : dst_off_q + AW'(1);
    end

    // Non-one-hot loads resolve toward the bottom row
    if (bus_ack_i) begin
      if (load2)      row_d[2] = bus_dat_i;
      else if (load1) row_d[1] = bus_dat_i;
      else if (load0) row_d[0] = bus_dat_i;
    end

    if (en_pipe) begin
      for (int r = 0; r < 3; r++) begin
        p_d[r][0] = p_q[r][1];
        p_d[r][1] = p_q[r][2];
        p_d[r][2] = row_q[r][{pix_cnt_q, 3'b000} +: PW];
      end
      pix_cnt_d = pix_cnt_q + 2'd1;
    end
    if (rst_a) pix_cnt_d = '0;

    if (s2_vld_q) begin
      dat_d[{s2_tag_q, 3'b000} +: PW] = mag_sat;
      if (s2_tag_q == 2'd3) vld_d = 1'b1;
    end
    // A new burst invalidates the held word even if the previous one completes this cycle
    if (en_pipe && (pix_cnt_q == 2'd0)) vld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_off_q <= '0;
      dst_off_q <= '0;
      for (int r = 0; r < 3; r++) begin
        row_q[r] <= '0;
        for (int c = 0; c < 3; c++) p_q[r][c] <= '0;
      end
      pix_cnt_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_tag_q  <= '0;
      dat_q     <= '0;
      vld_q     <= 1'b0;
    end else begin
      src_off_q <= src_off_d;
      dst_off_q <= dst_off_d;
      row_q     <= row_d;
      p_q       <= p_d;
      pix_cnt_q <= pix_cnt_d;
      s2_vld_q  <= s2_vld_d;
      s2_tag_q  <= s2_tag_d;
      dat_q     <= dat_d;
      vld_q     <= vld_d;
    end
  end

  assign bus_dat_o = dat_q;
  assign res_vld   = vld_q;

endmodule
